// File: rtl/divider_mantissa_seq_if.sv
// rtl/divider_mantissa_seq_if.sv - operand/result handshake bundle for the mantissa divider
//
// Purpose: groups the operand-side and result-side valid/ready handshakes of
// divider_mantissa_seq into one interface.
// Signals:
//   in_valid / in_ready       operand handshake
//   sig_a, sig_b              significands, hidden bit included (mant_width+1 bits)
//   exp_a, exp_b              signed unbiased exponents (exp_width+2 bits)
//   out_valid / out_ready     result handshake
//   unnorm_mant               quotient scaled by 2^(2m+1), sticky in bit 0
//   unnorm_exp                exp_a - exp_b - 1
//   div_zero                  divisor was zero
// Modports: master drives operands and out_ready, slave is the divider.
interface divider_mantissa_seq_if #(
  parameter int mant_width = 23,
  parameter int exp_width  = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [mant_width:0]           sig_a;
  logic [mant_width:0]           sig_b;
  logic signed [exp_width+1:0]   exp_a;
  logic signed [exp_width+1:0]   exp_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [2*mant_width+1:0]       unnorm_mant;
  logic signed [exp_width+1:0]   unnorm_exp;
  logic                          div_zero;

  modport master (
    output in_valid, sig_a, sig_b, exp_a, exp_b, out_ready,
    input  in_ready, out_valid, unnorm_mant, unnorm_exp, div_zero
  );

  modport slave (
    input  in_valid, sig_a, sig_b, exp_a, exp_b, out_ready,
    output in_ready, out_valid, unnorm_mant, unnorm_exp, div_zero
  );
endinterface

// File: rtl/divider_mantissa_seq.sv
// rtl/divider_mantissa_seq.sv - iterative radix-2 restoring significand divider
//
// Purpose: divides two normalised significands one quotient bit per cycle and
// presents {unnorm_mant, unnorm_exp} in the form the normaliser consumes.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; aborts any operation in flight
//   bus   divider_mantissa_seq_if.slave (operand and result handshakes)
module divider_mantissa_seq #(
  parameter int mant_width = 23,
  parameter int exp_width  = 8
) (
  input logic                   clk,
  input logic                   rst,
  divider_mantissa_seq_if.slave bus
);
  localparam int M  = mant_width;
  localparam int SW = M + 1;        // significand width
  localparam int RW = M + 2;        // remainder width: rem < 2*B before shift
  localparam int QW = 2 * M + 2;    // quotient width
  localparam int EW = exp_width + 2;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        b_q, b_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [QW-1:0]        q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic                 dz_q, dz_d;

  logic [RW-1:0]        b_ext;
  logic [RW-1:0]        diff;
  logic                 qbit;
  logic [CW-1:0]        qidx;
  logic                 last_iter;
  logic                 in_ready;
  logic                 out_valid;

  // One restoring step: subtract the divisor when it fits.
  always_comb begin
    b_ext     = {1'b0, b_q};
    qbit      = (rem_q >= b_ext);
    diff      = qbit ? (rem_q - b_ext) : rem_q;
    qidx      = CW'(QW - 1) - cnt_q;
    last_iter = (cnt_q == CW'(QW - 1));
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    rem_d     = rem_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    dz_d      = dz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          b_d   = bus.sig_b;
          rem_d = {1'b0, bus.sig_a};
          cnt_d = '0;
          exp_d = bus.exp_a - bus.exp_b - EW'(1);
          dz_d  = (bus.sig_b == '0);
          if (bus.sig_b == '0) begin
            // Saturated quotient; the normaliser treats it as don't-care.
            q_d     = '1;
            state_d = S_DONE;
          end else begin
            q_d     = '0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        rem_d     = diff << 1;
        q_d[qidx] = qbit;
        cnt_d     = cnt_q + CW'(1);
        if (last_iter) begin
          // Anything left over is folded into the sticky LSB.
          q_d[0]  = qbit | (diff != '0);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.unnorm_mant = q_q;
  assign bus.unnorm_exp  = exp_q;
  assign bus.div_zero    = dz_q;
endmodule

// File: tb/tb_divider_mantissa_seq.sv
// tb/tb_divider_mantissa_seq.sv - randomized self-checking bench for divider_mantissa_seq
module tb_divider_mantissa_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  divider_mantissa_seq_if #(.mant_width(23), .exp_width(8)) bus();
  divider_mantissa_seq_if #(.mant_width(3),  .exp_width(8)) bus3();

  divider_mantissa_seq #(.mant_width(23), .exp_width(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  divider_mantissa_seq #(.mant_width(3), .exp_width(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected results for the operation currently in flight on each DUT.
  logic               exp23_valid = 1'b0;
  logic [47:0]        e23_mant;
  logic signed [9:0]  e23_exp;
  logic               e23_dz;
  logic               exp3_valid = 1'b0;
  logic [7:0]         e3_mant;
  logic signed [9:0]  e3_exp;
  logic               e3_dz;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Quotient floor(a * 2^(2m+1) / b) with sticky remainder in bit 0.
  function automatic logic [127:0] model_mant(input int m, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] num, quo, rm, mask;
    mask = (128'd1 << (2 * m + 2)) - 128'd1;
    if (b == 64'd0) return mask;
    num = {64'd0, a} << (2 * m + 1);
    quo = num / {64'd0, b};
    rm  = num % {64'd0, b};
    return (quo | {127'd0, (rm != 128'd0)}) & mask;
  endfunction

  // Single compare process for both DUTs.
  always @(negedge clk) begin
    if (!rst) begin
      if (!exp23_valid) begin
        check("m23 out_valid with nothing pending", bus.out_valid, 1'b0);
      end else if (bus.out_valid) begin
        check("m23 unnorm_mant", bus.unnorm_mant, e23_mant);
        check("m23 unnorm_exp", bus.unnorm_exp, e23_exp);
        check("m23 div_zero", bus.div_zero, e23_dz);
        check("m23 in_ready in DONE", bus.in_ready, 1'b0);
      end
      if (!exp3_valid) begin
        check("m3 out_valid with nothing pending", bus3.out_valid, 1'b0);
      end else if (bus3.out_valid) begin
        check("m3 unnorm_mant", bus3.unnorm_mant, e3_mant);
        check("m3 unnorm_exp", bus3.unnorm_exp, e3_exp);
        check("m3 div_zero", bus3.div_zero, e3_dz);
        check("m3 in_ready in DONE", bus3.in_ready, 1'b0);
      end
    end
  end

  task automatic run23(input logic [23:0] a, input logic [23:0] b,
                       input logic signed [9:0] ea, input logic signed [9:0] eb,
                       input int hold, input bit early_rdy,
                       input bit lit, input logic [47:0] lit_mant, input logic signed [9:0] lit_exp);
    int n;
    bit seen;
    logic [127:0] t;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("m23 in_ready before issue", bus.in_ready, 1'b1);
    bus.sig_a     = a;
    bus.sig_b     = b;
    bus.exp_a     = ea;
    bus.exp_b     = eb;
    bus.in_valid  = 1'b1;
    bus.out_ready = early_rdy;
    t           = model_mant(23, {40'd0, a}, {40'd0, b});
    e23_mant    = t[47:0];
    e23_exp     = ea - eb - 10'sd1;
    e23_dz      = (b == 24'd0);
    exp23_valid = 1'b1;
    @(posedge clk);
    // Junk operands held valid while busy must be ignored.
    #1;
    bus.sig_a = 24'($urandom);
    bus.sig_b = 24'($urandom);
    bus.exp_a = 10'($urandom);
    bus.exp_b = 10'($urandom);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      seen = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    check("m23 latency", n, (b == 24'd0) ? 1 : 49);
    if (lit) begin
      check("m23 literal mant", bus.unnorm_mant, lit_mant);
      check("m23 literal exp", bus.unnorm_exp, lit_exp);
    end
    if (!early_rdy) begin
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    exp23_valid = 1'b0;
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("m23 in_ready after accept", bus.in_ready, 1'b1);
  endtask

  task automatic run3(input logic [3:0] a, input logic [3:0] b,
                      input logic signed [9:0] ea, input logic signed [9:0] eb,
                      input bit lit, input logic [7:0] lit_mant);
    int n;
    bit seen;
    logic [127:0] t;
    @(negedge clk);
    n = 0;
    while (!bus3.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("m3 in_ready before issue", bus3.in_ready, 1'b1);
    bus3.sig_a     = a;
    bus3.sig_b     = b;
    bus3.exp_a     = ea;
    bus3.exp_b     = eb;
    bus3.in_valid  = 1'b1;
    bus3.out_ready = 1'b0;
    t          = model_mant(3, {60'd0, a}, {60'd0, b});
    e3_mant    = t[7:0];
    e3_exp     = ea - eb - 10'sd1;
    e3_dz      = (b == 4'd0);
    exp3_valid = 1'b1;
    @(posedge clk);
    #1;
    bus3.in_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = bus3.out_valid;
    end
    check("m3 latency", n, (b == 4'd0) ? 1 : 9);
    if (lit) begin
      check("m3 literal mant", bus3.unnorm_mant, lit_mant);
    end
    bus3.out_ready = 1'b1;
    @(posedge clk);
    exp3_valid = 1'b0;
    #1;
    bus3.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [23:0] ra, rb;
    logic signed [9:0] rea, reb;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.sig_a      = '0;
    bus.sig_b      = '0;
    bus.exp_a      = '0;
    bus.exp_b      = '0;
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b0;
    bus3.sig_a     = '0;
    bus3.sig_b     = '0;
    bus3.exp_a     = '0;
    bus3.exp_b     = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset unnorm_mant", bus.unnorm_mant, 48'd0);
    check("reset unnorm_exp", bus.unnorm_exp, 10'sd0);
    check("reset div_zero", bus.div_zero, 1'b0);
    check("reset m3 in_ready", bus3.in_ready, 1'b1);
    rst = 1'b0;

    // Directed cases with hand-computed results.
    run23(24'h800000, 24'h800000, 10'sd5, 10'sd2, 0, 1'b0, 1'b1, 48'h8000_0000_0000, 10'sd2);
    run23(24'hC00000, 24'h800000, 10'sd0, 10'sd0, 0, 1'b1, 1'b1, 48'hC000_0000_0000, -10'sd1);
    run23(24'h800000, 24'hC00000, 10'sd3, 10'sd7, 0, 1'b0, 1'b1, 48'h5555_5555_5555, -10'sd5);
    run23(24'hF00000, 24'h900000, 10'sd1, 10'sd1, 10, 1'b0, 1'b0, 48'd0, 10'sd0);
    run23(24'h912345, 24'h000000, 10'sd4, 10'sd1, 0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF, 10'sd2);
    run23(24'hABCDEF, 24'h812345, -10'sd9, 10'sd4, 2, 1'b0, 1'b0, 48'd0, 10'sd0);
    run3(4'd8, 4'd10, 10'sd0, 10'sd0, 1'b1, 8'h67);

    // Reset during RUN drops the result and restores reset values.
    @(negedge clk);
    bus.sig_a    = 24'hA5A5A5;
    bus.sig_b    = 24'hC3C3C3;
    bus.exp_a    = 10'sd7;
    bus.exp_b    = 10'sd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid-run reset out_valid", bus.out_valid, 1'b0);
    check("mid-run reset in_ready", bus.in_ready, 1'b1);
    check("mid-run reset unnorm_mant", bus.unnorm_mant, 48'd0);
    check("mid-run reset unnorm_exp", bus.unnorm_exp, 10'sd0);
    rst = 1'b0;
    run23(24'h800000, 24'hC00000, 10'sd0, 10'sd0, 0, 1'b0, 1'b1, 48'h5555_5555_5555, -10'sd1);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      ra  = {1'b1, 23'($urandom)};
      rb  = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)};
      rea = 10'($signed($urandom_range(0, 400)) - 200);
      reb = 10'($signed($urandom_range(0, 400)) - 200);
      run23(ra, rb, rea, reb, $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 48'd0, 10'sd0);
    end

    // Every normalised operand pair plus zero divisor for the narrow divider.
    for (int a = 8; a < 16; a++) begin
      run3(4'(a), 4'd0, 10'sd1, 10'sd1, 1'b0, 8'd0);
      for (int b = 8; b < 16; b++) begin
        run3(4'(a), 4'(b), 10'($urandom_range(0, 100)), 10'($urandom_range(0, 100)), 1'b0, 8'd0);
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
